// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM power-up initialisation slice:
//   - SDRAM command encodings, driven as {cs_n, ras_n, cas_n, we_n}
//   - init_state_e, the state type of the initialisation sequencer
//   - state_cmd(), which maps a sequencer state to the command it issues
// There are no ports; the other files use this with import sdram_pkg::*.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AUTOREF   = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_PRE  = 3'd1,
        ST_TRP  = 3'd2,
        ST_REF  = 3'd3,
        ST_TRFC = 3'd4,
        ST_MRS  = 3'd5,
        ST_TMRD = 3'd6,
        ST_DONE = 3'd7
    } init_state_e;

    // Only the three one-cycle command states issue something other than NOP.
    function automatic logic [3:0] state_cmd(input init_state_e st);
        logic [3:0] cmd;
        case (st)
            ST_PRE:  cmd = CMD_PRECHARGE;
            ST_REF:  cmd = CMD_AUTOREF;
            ST_MRS:  cmd = CMD_MRS;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// -----------------------------------------------------------------------------
// sdram_refresh_timer
// Periodic refresh requester used once the SDRAM has been initialised.
// An interval counter runs while 'run' is high and reloads on every expiry,
// whether or not the previous request has been acknowledged.
//   clk_100m     in   clock, rising edge
//   rst_ddr_n    in   asynchronous active-low reset
//   run          in   count enable (high from init completion onward)
//   ref_ack      in   one-cycle acknowledge of ref_req
//   ref_req      out  refresh request level, set on expiry, cleared by ref_ack
//   ref_overrun  out  sticky: an interval expired while ref_req was still
//                     pending and unacknowledged; cleared only by reset
// -----------------------------------------------------------------------------
module sdram_refresh_timer #(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk_100m,
    input  logic rst_ddr_n,
    input  logic run,
    input  logic ref_ack,
    output logic ref_req,
    output logic ref_overrun
);

    localparam int                IW       = $clog2(REF_INTERVAL + 1);
    localparam logic [IW-1:0]     INT_LAST = IW'(REF_INTERVAL - 1);

    logic [IW-1:0] int_cnt_r;
    logic          ref_req_r;
    logic          ref_overrun_r;
    logic          expire_s;

    // Expiry strobe: last count of the interval while the timer is running.
    always_comb begin
        expire_s = 1'b0;
        if (run && (int_cnt_r == INT_LAST)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Interval counter, request level and sticky overrun flag.
    always_ff @(posedge clk_100m or negedge rst_ddr_n) begin
        if (!rst_ddr_n) begin
            int_cnt_r     <= {IW{1'b0}};
            ref_req_r     <= 1'b0;
            ref_overrun_r <= 1'b0;
        end else if (run) begin
            int_cnt_r <= expire_s ? {IW{1'b0}} : (int_cnt_r + IW'(1));
            if (expire_s) begin
                // A new expiry wins over a coincident ack: the fresh
                // interval needs its own refresh, so the request stays up.
                ref_req_r <= 1'b1;
                if (ref_req_r && !ref_ack) begin
                    ref_overrun_r <= 1'b1;
                end
            end else if (ref_ack) begin
                ref_req_r <= 1'b0;
            end
        end
    end

    assign ref_req     = ref_req_r;
    assign ref_overrun = ref_overrun_r;

endmodule

// File: rtl/sdram_init_seq.sv
// -----------------------------------------------------------------------------
// sdram_init_seq
// SDRAM power-up initialisation sequencer:
//   NOP wait -> PRECHARGE ALL -> INIT_REF_CNT x AUTO REFRESH -> MODE REGISTER
//   SET -> done. Each command is followed by its NOP recovery window.
// Optional build macro: SDRAM_AUTO_REFRESH_EN adds the periodic refresh
// timer (sdram_refresh_timer). Without it ref_req/ref_overrun are tied low
// and ref_ack is ignored.
// Ports:
//   clk_100m     in   sole clock, rising edge
//   rst_ddr_n    in   asynchronous active-low reset
//   sdr_cke      out  SDRAM clock enable
//   sdr_cmd      out  {cs_n, ras_n, cas_n, we_n}
//   sdr_addr     out  SDRAM address (A10 high on PRECHARGE, MODE_REG on MRS)
//   sdr_ba       out  bank address, always 2'b00
//   calc_done    out  initialisation complete (level)
//   ref_req      out  refresh request to the controller (level)
//   ref_ack      in   one-cycle acknowledge of ref_req
//   ref_overrun  out  sticky refresh overrun flag
// -----------------------------------------------------------------------------
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int          PWRUP_CYC    = 20000,
    parameter int          TRP_CYC      = 2,
    parameter int          TRFC_CYC     = 7,
    parameter int          TMRD_CYC     = 2,
    parameter int          INIT_REF_CNT = 8,
    parameter logic [12:0] MODE_REG     = 13'h0030,
    parameter int          REF_INTERVAL = 780
) (
    input  logic        clk_100m,
    input  logic        rst_ddr_n,
    output logic        sdr_cke,
    output logic [3:0]  sdr_cmd,
    output logic [12:0] sdr_addr,
    output logic [1:0]  sdr_ba,
    output logic        calc_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_overrun
);

    localparam int CNT_W  = $clog2(PWRUP_CYC + 1);
    localparam int RCNT_W = $clog2(INIT_REF_CNT + 1);

    // Last count value of each timed state. The wait states are only entered
    // when their parameter is above 1, so their "last" value is clamped.
    localparam logic [CNT_W-1:0]  PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0]  TRP_LAST   = CNT_W'((TRP_CYC  > 1) ? (TRP_CYC  - 2) : 0);
    localparam logic [CNT_W-1:0]  TRFC_LAST  = CNT_W'((TRFC_CYC > 1) ? (TRFC_CYC - 2) : 0);
    localparam logic [CNT_W-1:0]  TMRD_LAST  = CNT_W'((TMRD_CYC > 1) ? (TMRD_CYC - 2) : 0);
    localparam logic [RCNT_W-1:0] REF_LAST   = RCNT_W'(INIT_REF_CNT - 1);
    localparam logic [RCNT_W-1:0] REF_TOTAL  = RCNT_W'(INIT_REF_CNT);

    localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

    init_state_e        state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [RCNT_W-1:0]  ref_cnt_r;
    logic               sdr_cke_r;
    logic [3:0]         sdr_cmd_r;
    logic [12:0]        sdr_addr_r;
    logic               calc_done_r;

    // Sequencer. state_r names the phase whose command appears on the pins
    // at the next edge: the pin registers decode state_r, so the first edge
    // after reset release already shows NOP for the WAIT phase.
    always_ff @(posedge clk_100m or negedge rst_ddr_n) begin
        if (!rst_ddr_n) begin
            state_r     <= ST_WAIT;
            cnt_r       <= {CNT_W{1'b0}};
            ref_cnt_r   <= {RCNT_W{1'b0}};
            sdr_cke_r   <= 1'b0;
            sdr_cmd_r   <= CMD_INHIBIT;
            sdr_addr_r  <= 13'h0000;
            calc_done_r <= 1'b0;
        end else begin
            sdr_cke_r   <= 1'b1;
            sdr_cmd_r   <= state_cmd(state_r);
            calc_done_r <= (state_r == ST_DONE);
            case (state_r)
                ST_PRE:  sdr_addr_r <= ADDR_PRE_ALL;
                ST_MRS:  sdr_addr_r <= MODE_REG;
                default: sdr_addr_r <= 13'h0000;
            endcase

            case (state_r)
                ST_WAIT: begin
                    if (cnt_r == PWRUP_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_PRE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_PRE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= (TRP_CYC > 1) ? ST_TRP : ST_REF;
                end
                ST_TRP: begin
                    if (cnt_r == TRP_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_REF;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_REF: begin
                    ref_cnt_r <= ref_cnt_r + RCNT_W'(1);
                    cnt_r     <= {CNT_W{1'b0}};
                    if (TRFC_CYC > 1) begin
                        state_r <= ST_TRFC;
                    end else if (ref_cnt_r == REF_LAST) begin
                        state_r <= ST_MRS;
                    end else begin
                        state_r <= ST_REF;
                    end
                end
                ST_TRFC: begin
                    if (cnt_r == TRFC_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        // ref_cnt_r already counts the refresh just issued.
                        state_r <= (ref_cnt_r == REF_TOTAL) ? ST_MRS : ST_REF;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_MRS: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= (TMRD_CYC > 1) ? ST_TMRD : ST_DONE;
                end
                ST_TMRD: begin
                    if (cnt_r == TMRD_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_WAIT;
                end
            endcase
        end
    end

    assign sdr_cke   = sdr_cke_r;
    assign sdr_cmd   = sdr_cmd_r;
    assign sdr_addr  = sdr_addr_r;
    assign sdr_ba    = 2'b00;
    assign calc_done = calc_done_r;

`ifdef SDRAM_AUTO_REFRESH_EN
    sdram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh_timer (
        .clk_100m    (clk_100m),
        .rst_ddr_n   (rst_ddr_n),
        .run         (calc_done_r),
        .ref_ack     (ref_ack),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun)
    );
`else
    logic unused_refresh_s;
    assign unused_refresh_s = ref_ack & (REF_INTERVAL > 0);
    assign ref_req          = 1'b0;
    assign ref_overrun      = 1'b0;
`endif

endmodule
